seq_detect_ctrl: RTL and testbench

Run-time programmable serial pattern detector controller. Accepts a pattern of up to MAX_LEN bits through a ready/valid configuration port, scans a qualified serial bit stream for overlapping occurrences, counts matches and stops after a programmed match limit. It generalizes the fixed 4-bit and 6-bit sequence-detector FSMs into one configurable, sequenced resource with start, abort and done control.

---
 rtl/seq_detect_ctrl.sv | 141 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial pattern detector: pattern, length and match
// limit are loaded over a ready/valid port, then a qualified bit stream is scanned.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_limit,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               a_valid,
  input  logic               a,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, ARMED, SCAN, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);

  state_t             state_reg, state_next;
  // Only MAX_LEN-1 past bits are kept; the incoming bit completes the window.
  logic [MAX_LEN-2:0] history_reg, history_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [MAX_LEN-1:0] pattern_reg, pattern_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [CNT_W-1:0]   limit_reg, limit_next;
  logic               detected_reg, detected_next;
  logic               cfg_err_reg, cfg_err_next;
  logic               cfg_ready_reg, busy_reg, done_reg;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [CNT_W-1:0]   count_inc;
  logic               match;
  logic               cfg_fire;
  logic               len_ok;

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (gi < int'(len_reg));
  end

  assign window    = {history_reg, a};
  assign fill_inc  = (fill_reg == MAX_FILL) ? fill_reg : fill_reg + 1'b1;
  assign count_inc = (&count_reg) ? count_reg : count_reg + 1'b1;
  assign match     = (fill_inc >= len_reg) && (((window ^ pattern_reg) & len_mask) == '0);
  assign cfg_fire  = cfg_valid && (state_reg != SCAN);
  assign len_ok    = (cfg_len != '0) && (cfg_len <= MAX_FILL);

  always_comb begin
    state_next    = state_reg;
    history_next  = history_reg;
    fill_next     = fill_reg;
    count_next    = count_reg;
    pattern_next  = pattern_reg;
    len_next      = len_reg;
    limit_next    = limit_reg;
    detected_next = 1'b0;
    cfg_err_next  = 1'b0;

    if (abort && state_reg != IDLE) begin
      state_next   = ARMED;
      history_next = '0;
      fill_next    = '0;
    end else if (cfg_fire) begin
      if (len_ok) begin
        state_next   = ARMED;
        pattern_next = cfg_pattern;
        len_next     = cfg_len;
        limit_next   = cfg_limit;
        count_next   = '0;
      end else begin
        state_next   = IDLE;
        len_next     = '0;
        cfg_err_next = 1'b1;
      end
    end else if (start && (state_reg == ARMED || state_reg == DONE)) begin
      state_next   = SCAN;
      history_next = '0;
      fill_next    = '0;
      count_next   = '0;
    end else if (state_reg == SCAN && a_valid) begin
      history_next = window[MAX_LEN-2:0];
      fill_next    = fill_inc;
      if (match) begin
        detected_next = 1'b1;
        count_next    = count_inc;
        if (limit_reg != '0 && count_inc == limit_reg) state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      history_reg   <= '0;
      fill_reg      <= '0;
      count_reg     <= '0;
      pattern_reg   <= '0;
      len_reg       <= '0;
      limit_reg     <= '0;
      detected_reg  <= 1'b0;
      cfg_err_reg   <= 1'b0;
      cfg_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      history_reg   <= history_next;
      fill_reg      <= fill_next;
      count_reg     <= count_next;
      pattern_reg   <= pattern_next;
      len_reg       <= len_next;
      limit_reg     <= limit_next;
      detected_reg  <= detected_next;
      cfg_err_reg   <= cfg_err_next;
      cfg_ready_reg <= (state_next != SCAN);
      busy_reg      <= (state_next == SCAN);
      done_reg      <= (state_next == DONE);
    end
  end

  assign cfg_ready   = cfg_ready_reg;
  assign cfg_err     = cfg_err_reg;
  assign detected    = detected_reg;
  assign match_count = count_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: vector table, directed stream sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_seq_detect_ctrl;

  logic       clk, rst_n, cfg_valid, start, abort, a_valid, a;
  logic [7:0] cfg_pattern, cfg_limit;
  logic [3:0] cfg_len;
  logic       cfg_ready, cfg_err, detected, busy, done;
  logic [7:0] match_count;

  seq_detect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_limit(cfg_limit),
    .cfg_err(cfg_err), .start(start), .abort(abort), .a_valid(a_valid), .a(a),
    .detected(detected), .match_count(match_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: the bits seen since start/abort live in a queue.
  localparam int M_IDLE = 0, M_ARMED = 1, M_SCAN = 2, M_DONE = 3;
  int         m_mode = M_IDLE;
  bit         m_bits[$];
  int         m_len = 0, m_limit = 0, m_count = 0;
  logic [7:0] m_pat = '0;
  bit         m_det = 0, m_err = 0;

  task automatic model_step();
    if (!rst_n) begin
      m_mode = M_IDLE; m_bits.delete(); m_len = 0; m_count = 0; m_det = 0; m_err = 0;
    end else begin
      m_det = 0; m_err = 0;
      if (abort && m_mode != M_IDLE) begin
        m_mode = M_ARMED; m_bits.delete();
      end else if (cfg_valid && m_mode != M_SCAN) begin
        if (cfg_len >= 1 && cfg_len <= 8) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_limit = int'(cfg_limit);
          m_count = 0; m_mode = M_ARMED;
        end else begin
          m_mode = M_IDLE; m_err = 1;
        end
      end else if (start && (m_mode == M_ARMED || m_mode == M_DONE)) begin
        m_mode = M_SCAN; m_bits.delete(); m_count = 0;
      end else if (m_mode == M_SCAN && a_valid) begin
        bit hit;
        m_bits.push_back(a);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        hit = (m_bits.size() >= m_len);
        for (int j = 0; j < m_len && hit; j++)
          if (m_bits[m_bits.size() - 1 - j] != m_pat[j]) hit = 0;
        if (hit) begin
          m_det = 1;
          if (m_count < 255) m_count++;
          if (m_limit != 0 && m_count == m_limit) m_mode = M_DONE;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: advance the model, then compare every output after the edge.
  task automatic tick();
    logic [12:0] exp;
    model_step();
    exp = {m_mode != M_SCAN, m_err, m_det, m_mode == M_SCAN, m_mode == M_DONE, 8'(m_count)};
    @(posedge clk);
    #1;
    check("model", 32'({cfg_ready, cfg_err, detected, busy, done, match_count}), 32'(exp));
    cyc++;
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; start = 0; abort = 0; a_valid = 0; a = 0;
  endtask

  typedef struct {
    logic       cv;
    logic [3:0] len;
    logic [7:0] pat;
    logic       st, ab, av, a;
    logic       e_rdy, e_err, e_busy, e_done, e_det;
    logic [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit cv, int len, int pat, bit st, bit ab, bit av, bit ai,
                              bit rdy, bit err, bit bsy, bit dn, bit det, int cnt);
    vec_t v;
    v.cv = cv; v.len = 4'(len); v.pat = 8'(pat); v.st = st; v.ab = ab; v.av = av; v.a = ai;
    v.e_rdy = rdy; v.e_err = err; v.e_busy = bsy; v.e_done = dn; v.e_det = det; v.e_cnt = 8'(cnt);
    return v;
  endfunction

  // Configure, start, then feed the 24-bit reference stream MSB first.
  task automatic run_stream(input logic [7:0] pat, input int len, input int lim,
                            output logic [23:0] hits);
    logic [23:0] stream;
    stream = 24'b0011_0101_1001_1001_1010_1000;
    hits = '0;
    idle_inputs(); abort = 1; tick();
    idle_inputs(); cfg_valid = 1; cfg_pattern = pat; cfg_len = 4'(len); cfg_limit = 8'(lim); tick();
    idle_inputs(); start = 1; tick();
    idle_inputs();
    for (int i = 0; i < 24; i++) begin
      a_valid = 1; a = stream[23 - i];
      tick();
      hits[i] = detected;
    end
    idle_inputs();
  endtask

  vec_t        vt[18];
  logic [23:0] hits;
  int          ndet;

  initial begin
    rst_n = 0; cfg_pattern = '0; cfg_len = '0; cfg_limit = '0;
    idle_inputs();
    tick(); tick();
    check("reset_outputs", 32'({cfg_ready, cfg_err, detected, busy, done, match_count}), 32'(13'h1000));
    rst_n = 1;

    //          cv len pat   st ab av a   rdy err bsy dn det cnt
    vt[0]  = mk(1, 0, 8'h0A, 0, 0, 0, 0,  1,  1,  0,  0, 0,  0);
    vt[1]  = mk(0, 0, 8'h00, 1, 0, 0, 0,  1,  0,  0,  0, 0,  0);
    vt[2]  = mk(1, 9, 8'h0A, 0, 0, 0, 0,  1,  1,  0,  0, 0,  0);
    vt[3]  = mk(0, 0, 8'h00, 1, 0, 0, 0,  1,  0,  0,  0, 0,  0);
    vt[4]  = mk(1, 4, 8'h0A, 0, 0, 0, 0,  1,  0,  0,  0, 0,  0);
    vt[5]  = mk(0, 0, 8'h00, 1, 0, 0, 0,  0,  0,  1,  0, 0,  0);
    vt[6]  = mk(0, 0, 8'h00, 0, 0, 1, 1,  0,  0,  1,  0, 0,  0);
    vt[7]  = mk(0, 0, 8'h00, 0, 0, 1, 0,  0,  0,  1,  0, 0,  0);
    vt[8]  = mk(0, 0, 8'h00, 0, 0, 1, 1,  0,  0,  1,  0, 0,  0);
    vt[9]  = mk(0, 0, 8'h00, 0, 1, 0, 0,  1,  0,  0,  0, 0,  0);
    vt[10] = mk(0, 0, 8'h00, 1, 0, 0, 0,  0,  0,  1,  0, 0,  0);
    vt[11] = mk(0, 0, 8'h00, 0, 0, 1, 0,  0,  0,  1,  0, 0,  0);
    vt[12] = mk(0, 0, 8'h00, 0, 0, 1, 1,  0,  0,  1,  0, 0,  0);
    vt[13] = mk(0, 0, 8'h00, 0, 0, 1, 0,  0,  0,  1,  0, 0,  0);
    vt[14] = mk(0, 0, 8'h00, 0, 0, 1, 1,  0,  0,  1,  0, 0,  0);
    vt[15] = mk(0, 0, 8'h00, 0, 0, 1, 0,  0,  0,  1,  0, 1,  1);
    vt[16] = mk(1, 2, 8'h03, 0, 0, 1, 1,  0,  0,  1,  0, 0,  1);
    vt[17] = mk(0, 0, 8'h00, 0, 1, 1, 0,  1,  0,  0,  0, 0,  1);

    for (int i = 0; i < 18; i++) begin
      cfg_valid = vt[i].cv; cfg_len = vt[i].len; cfg_pattern = vt[i].pat; cfg_limit = '0;
      start = vt[i].st; abort = vt[i].ab; a_valid = vt[i].av; a = vt[i].a;
      tick();
      check("vector", 32'({cfg_ready, cfg_err, busy, done, detected, match_count}),
            32'({vt[i].e_rdy, vt[i].e_err, vt[i].e_busy, vt[i].e_done, vt[i].e_det, vt[i].e_cnt}));
      $display("vec %0d: rdy=%0b err=%0b busy=%0b done=%0b det=%0b cnt=%0d",
               i, cfg_ready, cfg_err, busy, done, detected, match_count);
    end
    idle_inputs();

    run_stream(8'b0000_1010, 4, 0, hits);
    check("p1010_hits", 32'(hits), 32'((1 << 6) | (1 << 19) | (1 << 21)));
    check("p1010_count_done", 32'({match_count, done}), 32'({8'd3, 1'b0}));
    $display("stream 1010 lim0: hits=%h cnt=%0d done=%0b", hits, match_count, done);

    run_stream(8'b0011_0011, 6, 0, hits);
    check("p110011_hits", 32'(hits), 32'((1 << 12) | (1 << 16)));
    check("p110011_count", 32'(match_count), 32'd2);
    $display("stream 110011 lim0: hits=%h cnt=%0d", hits, match_count);

    run_stream(8'b0000_1010, 4, 2, hits);
    check("limit_hits", 32'(hits), 32'((1 << 6) | (1 << 19)));
    check("limit_state", 32'({match_count, done, busy, cfg_ready}), 32'({8'd2, 1'b1, 1'b0, 1'b1}));
    $display("stream 1010 lim2: hits=%h cnt=%0d done=%0b", hits, match_count, done);

    // Pattern 11 with a_valid toggling, then reset in the middle of the stream.
    idle_inputs(); cfg_valid = 1; cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_limit = '0; tick();
    idle_inputs(); start = 1; tick();
    idle_inputs(); ndet = 0;
    for (int i = 0; i < 12; i++) begin
      a_valid = (i % 2 == 0); a = 1;
      tick();
      if (detected) ndet++;
      if (!a_valid) check("no_det_invalid", 32'(detected), 32'd0);
    end
    check("p11_det_count", 32'(ndet), 32'd5);
    check("p11_match_count", 32'(match_count), 32'd5);
    a_valid = 1; a = 1; rst_n = 0; tick();
    check("midscan_reset", 32'({cfg_ready, cfg_err, detected, busy, done, match_count}), 32'(13'h1000));
    $display("pattern 11 toggled: det=%0d then reset cnt=%0d", ndet, match_count);
    rst_n = 1; idle_inputs(); tick();

    // Randomized run, checked each cycle by the model inside tick().
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      rst_n       = (r != 0);
      cfg_valid   = (r >= 1 && r < 9);
      cfg_len     = 4'($urandom_range(0, 9));
      cfg_pattern = 8'($urandom);
      cfg_limit   = 8'($urandom_range(0, 4));
      start       = (r >= 9 && r < 25);
      abort       = (r >= 25 && r < 29);
      a_valid     = ($urandom_range(0, 3) != 0);
      a           = 1'($urandom);
      tick();
      if (cfg_valid)
        $display("rand cfg len=%0d pat=%h lim=%0d -> err=%0b rdy=%0b cnt=%0d",
                 cfg_len, cfg_pattern, cfg_limit, cfg_err, cfg_ready, match_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
